// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin arbiter sharing one pmem line port between icache and dcache
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    input  logic                  i_read,
    input  logic                  i_write,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    input  logic                  d_read,
    input  logic                  d_write,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic [31:0]           i_count,
    output logic [31:0]           d_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    // last_grant encoding; it also names the owner during I_BUSY/D_BUSY/RESP
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]           i_count_q, i_count_d;
    logic [31:0]           d_count_q, d_count_d;

    logic i_req;
    logic d_req;
    logic pick_d;
    logic busy;

    assign i_req  = i_read | i_write;
    assign d_req  = d_read | d_write;
    // dcache wins when alone, or on a tie when icache was served last
    assign pick_d = d_req & (~i_req | (last_grant_q == GRANT_I));
    assign busy   = (state_q == I_BUSY) || (state_q == D_BUSY);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = pick_d ? D_BUSY : I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant latch, returned line and completion counters
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            i_count_q    <= '0;
            d_count_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            i_count_q    <= i_count_d;
            d_count_q    <= d_count_d;
        end
    end

    // Latch the winner's request at grant; capture pmem data and count on completion
    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        i_count_d    = i_count_q;
        d_count_d    = d_count_q;
        if ((state_q == IDLE) && (i_req || d_req)) begin
            last_grant_d = pick_d ? GRANT_D : GRANT_I;
            addr_d       = pick_d ? d_address : i_address;
            wdata_d      = pick_d ? d_wdata : i_wdata;
            // write has priority if a requester raises both strobes
            write_d      = pick_d ? d_write : i_write;
        end
        if (busy && pmem_resp) begin
            rdata_d = pmem_rdata;
            if (state_q == I_BUSY) begin
                i_count_d = i_count_q + 32'd1;
            end else begin
                d_count_d = d_count_q + 32'd1;
            end
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        pmem_read    = busy & ~write_q;
        pmem_write   = busy & write_q;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        if (state_q == RESP) begin
            if (last_grant_q == GRANT_I) begin
                i_resp  = 1'b1;
                i_rdata = rdata_q;
            end else begin
                d_resp  = 1'b1;
                d_rdata = rdata_q;
            end
        end
        i_count = i_count_q;
        d_count = d_count_q;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_address, d_address, pmem_address;
    logic [255:0] i_wdata, d_wdata, i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic         i_read, i_write, i_resp, d_read, d_write, d_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [31:0]  i_count, d_count;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        bit           is_d;
        logic [255:0] data;
    } exp_t;
    exp_t sb[$];

    cache_mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_wdata(i_wdata), .i_read(i_read), .i_write(i_write),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_address(d_address), .d_wdata(d_wdata), .d_read(d_read), .d_write(d_write),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .i_count(i_count), .d_count(d_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops the scoreboard and releases the owner's strobes
    always @(negedge clk) begin
        if (i_resp || d_resp) begin
            check("resp_exclusive", i_resp & d_resp, 0);
            check("resp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_owner", d_resp, e.is_d);
                check("resp_rdata", d_resp ? d_rdata : i_rdata, e.data);
                check("nonowner_rdata", d_resp ? i_rdata : d_rdata, 0);
            end
            if (i_resp) begin i_read = 1'b0; i_write = 1'b0; end
            if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
        end
    end

    // pmem model: waits for a strobe, checks it for `hold` cycles, responds in the last one
    task automatic serve(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                         input logic [255:0] rd, input int hold, output int wait_n);
        wait_n = 0;
        while (!(pmem_read || pmem_write) && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check("strobe_timeout", wait_n < 20, 1);
        for (int c = 1; c <= hold; c++) begin
            check("pmem_write", pmem_write, wr);
            check("pmem_read", pmem_read, !wr);
            check("pmem_address", pmem_address, addr);
            check("pmem_wdata", pmem_wdata, wd);
            if (c == hold) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end
            @(negedge clk);
        end
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        check("strobe_drop", {pmem_read, pmem_write}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] a5, iw, dw, r1, r2, r3, r4, w6;
        logic [31:0]  snap;
        int           n;
        a5 = {32{8'hA5}};
        iw = {8{32'h1111_2222}};
        dw = {8{32'hDEAD_BEEF}};
        r1 = {8{32'h0101_0101}};
        r2 = {8{32'h0202_0202}};
        r3 = {8{32'h0303_0303}};
        r4 = {8{32'h0404_0404}};
        w6 = {8{32'h6666_7777}};
        i_address = '0; i_wdata = '0; i_read = 0; i_write = 0;
        d_address = '0; d_wdata = '0; d_read = 0; d_write = 0;
        pmem_rdata = '0; pmem_resp = 0;
        do_reset();

        // Reset state
        check("rst_pmem_strobes", {pmem_read, pmem_write}, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        check("rst_resps", {i_resp, d_resp}, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_counts", {i_count, d_count}, 0);

        // Lone icache read, pmem responds in the 5th strobe cycle
        i_address = 32'h0000_1000; i_read = 1'b1;
        sb.push_back('{1'b0, a5});
        @(negedge clk);
        serve(1'b0, 32'h0000_1000, '0, a5, 5, n);
        check("lone_grant_latency", n, 0);
        check("lone_i_resp_cycle", i_resp, 1);
        @(negedge clk);
        check("lone_i_resp_one_cycle", i_resp, 0);
        check("lone_i_count", i_count, 1);
        check("lone_d_count", d_count, 0);

        // Tie out of reset: dcache first, then icache back-to-back
        do_reset();
        i_address = 32'h100; i_wdata = iw; i_read = 1'b1;
        d_address = 32'h200; d_wdata = dw; d_write = 1'b1;
        sb.push_back('{1'b1, r1});
        sb.push_back('{1'b0, r2});
        @(negedge clk);
        serve(1'b1, 32'h200, dw, r1, 2, n);
        check("tie1_first_latency", n, 0);
        serve(1'b0, 32'h100, iw, r2, 3, n);
        check("back_to_back_latency", n, 2);
        @(negedge clk);

        // Lone dcache read, so the next tie goes to icache
        d_address = 32'h300; d_read = 1'b1;
        sb.push_back('{1'b1, r3});
        @(negedge clk);
        serve(1'b0, 32'h300, dw, r3, 2, n);
        @(negedge clk);
        i_address = 32'h140; i_read = 1'b1;
        d_address = 32'h240; d_read = 1'b1;
        sb.push_back('{1'b0, r4});
        sb.push_back('{1'b1, r1});
        @(negedge clk);
        serve(1'b0, 32'h140, iw, r4, 1, n);
        serve(1'b0, 32'h240, dw, r1, 1, n);
        @(negedge clk);
        check("tie_i_count", i_count, 2);
        check("tie_d_count", d_count, 3);

        // dcache inputs change while D_BUSY; pmem must keep the latched values
        d_address = 32'h600; d_wdata = w6; d_write = 1'b1;
        sb.push_back('{1'b1, r2});
        @(negedge clk);
        fork
            serve(1'b1, 32'h600, w6, r2, 4, n);
            begin
                repeat (3) begin
                    d_address = $urandom;
                    d_wdata   = {8{$urandom}};
                    @(negedge clk);
                end
            end
        join
        @(negedge clk);

        // Both read and write from dcache: write wins
        d_address = 32'h700; d_wdata = dw; d_read = 1'b1; d_write = 1'b1;
        sb.push_back('{1'b1, r3});
        @(negedge clk);
        serve(1'b1, 32'h700, dw, r3, 3, n);
        @(negedge clk);

        // Reset two cycles into I_BUSY, late pmem_resp must be ignored
        i_address = 32'h3000; i_read = 1'b1;
        @(negedge clk);
        check("abort_strobe_up", pmem_read, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_strobe_drop", {pmem_read, pmem_write}, 0);
        check("abort_no_resp", {i_resp, d_resp}, 0);
        rst = 1'b0; i_read = 1'b0; pmem_resp = 1'b1; pmem_rdata = a5;
        @(negedge clk);
        pmem_resp = 1'b0; pmem_rdata = '0;
        for (int c = 0; c < 3; c++) begin
            check("abort_idle_strobes", {pmem_read, pmem_write}, 0);
            check("abort_idle_resp", {i_resp, d_resp}, 0);
            check("abort_counts", {i_count, d_count}, 0);
            @(negedge clk);
        end
        i_address = 32'h4000; i_read = 1'b1;
        sb.push_back('{1'b0, r4});
        @(negedge clk);
        serve(1'b0, 32'h4000, iw, r4, 2, n);
        check("post_abort_grant_latency", n, 0);
        @(negedge clk);

        // i_count wraps at 2^32 without disturbing d_count
        force dut.i_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.i_count_q;
        snap = d_count;
        i_address = 32'h5000; i_read = 1'b1;
        sb.push_back('{1'b0, a5});
        @(negedge clk);
        serve(1'b0, 32'h5000, iw, a5, 2, n);
        @(negedge clk);
        check("wrap_i_count", i_count, 0);
        check("wrap_d_count", d_count, snap);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
